// File: rtl/sccb_init_seq.sv
// Walks an external {reg, val} table at power-up or on start and issues one SCCB write per entry.
// Define SCCB_READBACK_EN to add a read-back verify of each write (m_rd, m_rdata, mismatch).
module sccb_init_seq #(
  parameter logic [7:0]  DEV_ADDR    = 8'h42,
  parameter int unsigned TBL_AW      = 6,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned GAP_CYCLES  = 16,
  parameter int unsigned DELAY_TICKS = 1000
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  output logic              m_req,
  output logic [7:0]        m_dev,
  output logic [7:0]        m_reg,
  output logic [7:0]        m_wdata,
  input  logic              m_done,
  input  logic              m_nack,
`ifdef SCCB_READBACK_EN
  output logic              m_rd,
  input  logic [7:0]        m_rdata,
  output logic              mismatch,
`endif
  output logic              busy,
  output logic              cfg_done,
  output logic              error,
  output logic [TBL_AW-1:0] err_idx
);

  localparam int unsigned DlyW = 8 + $clog2(DELAY_TICKS);
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned CntW = (DlyW > GapW) ? DlyW : GapW;
  localparam int unsigned RtyW = $clog2(MAX_RETRY + 2);
  localparam logic [CntW-1:0] GapLoad = CntW'(GAP_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StWrite, StVerify, StGap, StDelay, StDone, StError
  } state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic [RtyW-1:0] retry;
  logic            retry_pend;
  logic            auto_run;

  // tbl_addr doubles as the current entry index.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state      <= StIdle;
      tbl_addr   <= '0;
      m_req      <= 1'b0;
      m_dev      <= '0;
      m_reg      <= '0;
      m_wdata    <= '0;
      busy       <= 1'b0;
      cfg_done   <= 1'b0;
      error      <= 1'b0;
      err_idx    <= '0;
      cnt        <= '0;
      retry      <= '0;
      retry_pend <= 1'b0;
      auto_run   <= 1'b1;
`ifdef SCCB_READBACK_EN
      m_rd       <= 1'b0;
      mismatch   <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (start || auto_run) begin
            auto_run   <= 1'b0;
            tbl_addr   <= '0;
            retry      <= '0;
            retry_pend <= 1'b0;
            busy       <= 1'b1;
            cfg_done   <= 1'b0;
            error      <= 1'b0;
`ifdef SCCB_READBACK_EN
            mismatch   <= 1'b0;
`endif
            state      <= StFetch;
          end
        end
        StFetch: state <= StDecode;
        StDecode: begin
          if (tbl_data == 16'hFFFF) begin
            state <= StDone;
          end else if (tbl_data[15:8] == 8'hF0) begin
            if (tbl_data[7:0] == 8'h00) begin
              cnt   <= GapLoad;
              state <= StGap;
            end else begin
              cnt   <= CntW'(tbl_data[7:0]) * CntW'(DELAY_TICKS) - CntW'(1);
              state <= StDelay;
            end
          end else begin
            m_dev   <= DEV_ADDR;
            m_reg   <= tbl_data[15:8];
            m_wdata <= tbl_data[7:0];
            m_req   <= 1'b1;
            state   <= StWrite;
          end
        end
        StWrite: begin
          if (m_done) begin
            m_req <= 1'b0;
            if (m_nack) begin
              if (retry < RtyW'(MAX_RETRY)) begin
                retry      <= retry + RtyW'(1);
                retry_pend <= 1'b1;
                cnt        <= GapLoad;
                state      <= StGap;
              end else begin
                state <= StError;
              end
            end else begin
`ifdef SCCB_READBACK_EN
              m_rd  <= 1'b1;
              state <= StVerify;
`else
              cnt   <= GapLoad;
              state <= StGap;
`endif
            end
          end
        end
        StVerify: begin
`ifdef SCCB_READBACK_EN
          // m_req is low for one cycle so the read is a fresh request.
          if (!m_req) begin
            m_req <= 1'b1;
          end else if (m_done) begin
            m_req <= 1'b0;
            m_rd  <= 1'b0;
            if (m_nack) begin
              if (retry < RtyW'(MAX_RETRY)) begin
                retry      <= retry + RtyW'(1);
                retry_pend <= 1'b1;
                cnt        <= GapLoad;
                state      <= StGap;
              end else begin
                state <= StError;
              end
            end else begin
              if (m_rdata != m_wdata) begin
                mismatch <= 1'b1;
                err_idx  <= tbl_addr;
              end
              cnt   <= GapLoad;
              state <= StGap;
            end
          end
`else
          state <= StIdle;
`endif
        end
        StGap: begin
          if (cnt == '0) begin
            if (retry_pend) begin
              retry_pend <= 1'b0;
              state      <= StFetch;
            end else if (&tbl_addr) begin
              state <= StDone;
            end else begin
              tbl_addr <= tbl_addr + TBL_AW'(1);
              retry    <= '0;
              state    <= StFetch;
            end
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        StDelay: begin
          if (cnt == '0) begin
            cnt   <= GapLoad;
            state <= StGap;
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        StDone: begin
          cfg_done <= 1'b1;
          busy     <= 1'b0;
          state    <= StIdle;
        end
        StError: begin
          error   <= 1'b1;
          err_idx <= tbl_addr;
          busy    <= 1'b0;
          state   <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_init_seq.sv
// Randomized bench for sccb_init_seq: transaction-level model of the table walk plus a master model.
module tb_sccb_init_seq;

  localparam int G  = 16;
  localparam int D  = 1000;
  localparam int MR = 3;
  localparam int N  = 64;

  logic        clk = 1'b0;
  logic        res_n, start, m_done, m_nack;
  logic [5:0]  tbl_addr, err_idx;
  logic [15:0] tbl_data;
  logic        m_req, busy, cfg_done, error;
  logic [7:0]  m_dev, m_reg, m_wdata;

  always #5 clk = ~clk;

  sccb_init_seq dut (
    .clk      (clk),
    .res_n    (res_n),
    .start    (start),
    .tbl_addr (tbl_addr),
    .tbl_data (tbl_data),
    .m_req    (m_req),
    .m_dev    (m_dev),
    .m_reg    (m_reg),
    .m_wdata  (m_wdata),
    .m_done   (m_done),
    .m_nack   (m_nack),
    .busy     (busy),
    .cfg_done (cfg_done),
    .error    (error),
    .err_idx  (err_idx)
  );

  logic [15:0] tbl_mem [N];
  int          nack_plan [N];

  // Synchronous table ROM: data one clock after the address.
  always @(posedge clk) tbl_data <= tbl_mem[tbl_addr];

  typedef struct {
    logic [7:0] rg;
    logic [7:0] wd;
    logic       nack;
    int         min_gap;
    int         max_gap;
  } item_t;

  item_t      exp_q[$];
  item_t      cur;
  int         checks = 0;
  int         errors = 0;
  int         req_seen = 0;
  logic       exp_cfg, exp_err;
  logic [5:0] exp_eidx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected request stream and final status, straight from the table rules.
  function automatic void build_model();
    int dsum = 0;
    int k = 0;
    bit first = 1'b1;
    item_t it;
    exp_q.delete();
    exp_err = 1'b0;
    exp_cfg = 1'b1;
    exp_eidx = '0;
    for (int idx = 0; idx < N; idx++) begin
      logic [15:0] w;
      int nreq;
      w = tbl_mem[idx];
      if (w == 16'hFFFF) return;
      if (w[15:8] == 8'hF0) begin
        dsum += int'(w[7:0]) * D;
        k++;
      end else begin
        nreq = (nack_plan[idx] > MR) ? MR + 1 : nack_plan[idx] + 1;
        for (int a = 0; a < nreq; a++) begin
          it.rg = w[15:8];
          it.wd = w[7:0];
          it.nack = (a < nack_plan[idx]);
          if (first) begin
            it.min_gap = 0;
            it.max_gap = 1 << 30;
          end else begin
            it.min_gap = G + dsum;
            it.max_gap = G + dsum + (G + 8) * (k + 1);
          end
          exp_q.push_back(it);
          first = 1'b0;
          dsum = 0;
          k = 0;
        end
        if (nack_plan[idx] > MR) begin
          exp_cfg = 1'b0;
          exp_err = 1'b1;
          exp_eidx = 6'(idx);
          return;
        end
      end
    end
  endfunction

  // Master model and per-cycle compare.
  logic prev_req = 1'b0;
  logic done_sent = 1'b0;
  int   wcnt = 0;
  int   low_cnt = 0;

  always @(negedge clk) begin
    m_done = 1'b0;
    m_nack = 1'b0;
    if (!res_n) begin
      prev_req = 1'b0;
      done_sent = 1'b0;
      low_cnt = 0;
    end else begin
      if (done_sent) begin
        chk("req_drop", 32'(m_req), 32'd0);
        done_sent = 1'b0;
      end else if (m_req) begin
        chk("busy_with_req", 32'(busy), 32'd1);
        if (!prev_req) begin
          req_seen++;
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_req actual=%0h%0h required=none", m_reg, m_wdata);
          end else begin
            cur = exp_q.pop_front();
            chk("m_reg", 32'(m_reg), 32'(cur.rg));
            chk("m_wdata", 32'(m_wdata), 32'(cur.wd));
            chk("m_dev", 32'(m_dev), 32'h42);
            checks++;
            if (low_cnt < cur.min_gap || low_cnt > cur.max_gap) begin
              errors++;
              $display("FAIL gap actual=%0d required=%0d..%0d", low_cnt, cur.min_gap,
                       cur.max_gap);
            end
            wcnt = $urandom_range(0, 3);
          end
        end else begin
          chk("fields_stable", {8'h0, m_dev, m_reg, m_wdata}, {8'h0, 8'h42, cur.rg, cur.wd});
        end
        if (wcnt <= 0) begin
          m_done = 1'b1;
          m_nack = cur.nack;
          done_sent = 1'b1;
        end else begin
          wcnt--;
        end
        low_cnt = 0;
      end
      if (!m_req) begin
        low_cnt++;
        // Stray completions outside a transaction must be ignored.
        if (busy && !done_sent && $urandom_range(0, 7) == 0) begin
          m_done = 1'b1;
          m_nack = 1'($urandom_range(0, 1));
        end
      end
      prev_req = m_req;
    end
  end

  task automatic clear_tbl();
    for (int i = 0; i < N; i++) begin
      tbl_mem[i] = 16'hFFFF;
      nack_plan[i] = 0;
    end
  endtask

  task automatic wait_run(input int pulse_at);
    int n = 0;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("busy_rise", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 40000) begin
      @(negedge clk);
      n++;
      if (n == pulse_at) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n++;
      end
    end
    chk("busy_fall", 32'(busy), 32'd0);
    @(negedge clk);
    chk("cfg_done", 32'(cfg_done), 32'(exp_cfg));
    chk("error", 32'(error), 32'(exp_err));
    if (exp_err) chk("err_idx", 32'(err_idx), 32'(exp_eidx));
    chk("exp_left", 32'(exp_q.size()), 32'd0);
    chk("idle_req", 32'(m_req), 32'd0);
  endtask

  task automatic run_start(input int pulse_at);
    build_model();
    req_seen = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_run(pulse_at);
  endtask

  task automatic run_reset();
    build_model();
    req_seen = 0;
    res_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tbl_addr", 32'(tbl_addr), 32'd0);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_fields", {8'h0, m_dev, m_reg, m_wdata}, 32'd0);
    chk("rst_status", {busy, cfg_done, error}, 32'd0);
    chk("rst_err_idx", 32'(err_idx), 32'd0);
    res_n = 1'b1;
    wait_run(-1);
  endtask

  initial begin
    int n;
    res_n = 1'b0;
    start = 1'b0;
    m_done = 1'b0;
    m_nack = 1'b0;
    clear_tbl();
    @(negedge clk);

    // Automatic run after reset release.
    tbl_mem[0] = 16'h1280;
    tbl_mem[1] = 16'h1101;
    run_reset();
    chk("t1_reqs", 32'(req_seen), 32'd2);
    chk("t1_cfg_done", 32'(cfg_done), 32'd1);

    // Delay entry between two writes.
    clear_tbl();
    tbl_mem[0] = 16'h1280;
    tbl_mem[1] = 16'hF002;
    tbl_mem[2] = 16'h1101;
    run_start(-1);
    chk("t2_reqs", 32'(req_seen), 32'd2);

    // Three NACKs on idx 1, then ACK.
    clear_tbl();
    tbl_mem[0] = 16'h1280;
    tbl_mem[1] = 16'h1101;
    nack_plan[1] = 3;
    run_start(-1);
    chk("t3_reqs", 32'(req_seen), 32'd5);
    chk("t3_cfg_done", 32'(cfg_done), 32'd1);

    // Four NACKs on idx 2: retries exhausted.
    clear_tbl();
    tbl_mem[0] = 16'h1280;
    tbl_mem[1] = 16'h1101;
    tbl_mem[2] = 16'h1A55;
    tbl_mem[3] = 16'h3C3C;
    nack_plan[2] = 4;
    run_start(-1);
    chk("t4_err_idx", 32'(err_idx), 32'd2);
    chk("t4_status", {busy, cfg_done, error}, 32'b001);
    repeat (60) @(negedge clk);
    chk("t4_reqs", 32'(req_seen), 32'd6);

    // start pulsed mid-run is ignored; zero-length delay goes straight to GAP.
    clear_tbl();
    tbl_mem[0] = 16'h1280;
    tbl_mem[1] = 16'hF000;
    tbl_mem[2] = 16'h1101;
    tbl_mem[3] = 16'h3344;
    run_start(30);
    chk("t5_reqs", 32'(req_seen), 32'd3);

    // Reset asserted during WRITE, then the run restarts from idx 0.
    clear_tbl();
    tbl_mem[0] = 16'h1280;
    tbl_mem[1] = 16'h1101;
    build_model();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!m_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_write", 32'(m_req), 32'd1);
    res_n = 1'b0;
    @(negedge clk);
    chk("t6_req_drop", 32'(m_req), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    build_model();
    req_seen = 0;
    res_n = 1'b1;
    wait_run(-1);
    chk("t6_reqs", 32'(req_seen), 32'd2);

    // No end marker: every entry up to the last index runs, no wrap to 0.
    clear_tbl();
    for (int i = 0; i < N; i++) tbl_mem[i] = {8'h20 + 8'(i), 8'(i * 3)};
    run_start(-1);
    chk("t7_reqs", 32'(req_seen), 32'd64);
    chk("t7_cfg_done", 32'(cfg_done), 32'd1);

    // Random tables with random delays and NACK patterns.
    for (int r = 0; r < 6; r++) begin
      int len;
      logic [7:0] rg, wd;
      clear_tbl();
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 4) == 0) begin
          tbl_mem[i] = {8'hF0, 8'($urandom_range(0, 1))};
        end else begin
          rg = 8'($urandom_range(0, 255));
          wd = 8'($urandom_range(0, 255));
          if (rg == 8'hF0) rg = 8'hF1;
          if ({rg, wd} == 16'hFFFF) wd = 8'hFE;
          tbl_mem[i] = {rg, wd};
          nack_plan[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
        end
      end
      run_start(-1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
